// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-through data cache controller.
// 16-byte lines, no write allocate, 128-bit block refills.
module data_cache_ctrl #(
  parameter int NUM_LINES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [31:0]  cpu_addr,
  input  logic [63:0]  cpu_wdata,
  output logic [63:0]  cpu_rdata,
  output logic         cpu_ready,
  output logic [31:0]  mem_address,
  output logic [63:0]  mem_write_data,
  output logic         mem_write,
  output logic         mem_read,
  input  logic [127:0] mem_block_data,
  input  logic         mem_ready
);

  localparam int IDX = $clog2(NUM_LINES);
  localparam int TW  = 28 - IDX;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]           state_q;
  logic                 armed_q;
  logic [31:3]          req_dw_q;
  logic [63:0]          req_wdata_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TW-1:0]        tag_q  [NUM_LINES];
  logic [127:0]         data_q [NUM_LINES];

  logic [IDX-1:0] c_idx;
  logic [IDX-1:0] r_idx;
  logic [TW-1:0]  c_tag;
  logic [TW-1:0]  r_tag;
  logic [127:0]   c_line;
  logic [63:0]    c_dw;
  logic [63:0]    blk_dw;
  logic           c_hit;
  logic           r_hit;
  logic           fill;
  logic           upd;

  assign c_idx  = cpu_addr[4+IDX-1:4];
  assign c_tag  = cpu_addr[31:4+IDX];
  assign c_line = data_q[c_idx];
  assign c_dw   = cpu_addr[3] ? c_line[127:64]
                              : c_line[63:0];
  assign c_hit  = valid_q[c_idx] &&
                  (tag_q[c_idx] == c_tag);

  assign r_idx  = req_dw_q[4+IDX-1:4];
  assign r_tag  = req_dw_q[31:4+IDX];
  assign r_hit  = valid_q[r_idx] &&
                  (tag_q[r_idx] == r_tag);
  assign blk_dw = req_dw_q[3] ? mem_block_data[127:64]
                              : mem_block_data[63:0];

  // armed_q guarantees mem_ready was seen low first, so a
  // ready left over from the previous refill is never taken.
  assign fill = (state_q == RD_WAIT) && armed_q && mem_ready;
  assign upd  = (state_q == WRITE) && r_hit;

  assign cpu_ready = (state_q == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      armed_q        <= 1'b0;
      req_dw_q       <= '0;
      req_wdata_q    <= '0;
      valid_q        <= '0;
      cpu_rdata      <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cpu_req) begin
            req_dw_q    <= cpu_addr[31:3];
            req_wdata_q <= cpu_wdata;
            unique case (1'b1)
              cpu_we: begin
                mem_write      <= 1'b1;
                mem_address    <= cpu_addr & ~32'h7;
                mem_write_data <= cpu_wdata;
                state_q        <= WRITE;
              end
              !cpu_we && c_hit: begin
                cpu_rdata <= c_dw;
                state_q   <= RESP;
              end
              !cpu_we && !c_hit: begin
                mem_read    <= 1'b1;
                mem_address <= cpu_addr & ~32'hF;
                state_q     <= RD_WAIT;
              end
            endcase
          end
        end
        WRITE: begin
          mem_write <= 1'b0;
          state_q   <= RESP;
        end
        RD_WAIT: begin
          if (!mem_ready) begin
            armed_q <= 1'b1;
          end
          if (fill) begin
            mem_read         <= 1'b0;
            armed_q          <= 1'b0;
            valid_q[r_idx]   <= 1'b1;
            cpu_rdata        <= blk_dw;
            state_q          <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid_q guards them.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[r_idx] <= mem_block_data;
      tag_q[r_idx]  <= r_tag;
    end else if (upd) begin
      if (req_dw_q[3]) begin
        data_q[r_idx][127:64] <= req_wdata_q;
      end else begin
        data_q[r_idx][63:0] <= req_wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed testbench for data_cache_ctrl with a block-memory
// model whose ready lingers after a refill.
module tb_data_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [63:0]  cpu_wdata = '0;
  logic [63:0]  cpu_rdata;
  logic         cpu_ready;
  logic [31:0]  mem_address;
  logic [63:0]  mem_write_data;
  logic         mem_write;
  logic         mem_read;
  logic [127:0] mem_block_data = '0;
  logic         mem_ready = 1'b0;

  always #5 clk = ~clk;

  data_cache_ctrl #(.NUM_LINES(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_ready      (cpu_ready),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_block_data (mem_block_data),
    .mem_ready      (mem_ready)
  );

  logic [7:0] mem [1024];
  logic       mem_init = 1'b0;
  int         rd_cnt = 0;
  int         st_cnt = 0;

  // ready rises on the third read cycle and stays high for
  // three cycles after mem_read drops
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int a = 0; a < 1024; a++) begin
        if (a >= 64 && a < 80)
          mem[10'(a)] <= 8'(a - 64);
        else
          mem[10'(a)] <= 8'(a + 16 * (a / 256));
      end
      mem_init <= 1'b1;
    end else begin
      if (mem_write) begin
        for (int k = 0; k < 8; k++)
          mem[mem_address[9:0] + 10'(k)] <= mem_write_data[8*k +: 8];
      end
      if (mem_read) rd_cnt <= rd_cnt + 1;
      else          rd_cnt <= 0;
      if (mem_read && rd_cnt == 1) begin
        mem_ready <= 1'b1;
        st_cnt    <= 0;
        for (int k = 0; k < 16; k++)
          mem_block_data[8*k +: 8] <= mem[mem_address[9:0] + 10'(k)];
      end else if (mem_ready && !(mem_read && rd_cnt >= 2)) begin
        st_cnt <= st_cnt + 1;
        if (st_cnt == 2) mem_ready <= 1'b0;
      end
    end
  end

  int cyc = 0;
  int ready_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cpu_ready) ready_cnt <= ready_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          lat;
  int          rd_n;
  int          rd_first;
  int          wr_n;
  int          wr_first;
  int          rdy_cyc;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic [63:0] rdat;

  task automatic access(input logic we,
                        input logic [31:0] addr,
                        input logic [63:0] wd);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    @(negedge clk);
    cpu_req   = 1'b0;
    cpu_we    = ~we;
    cpu_addr  = $urandom;
    cpu_wdata = {$urandom, $urandom};
    lat = 99; rd_n = 0; rd_first = 0;
    wr_n = 0; wr_first = 0; rdy_cyc = 0;
    wr_addr = '0; wr_data = '0; rdat = '0;
    for (int c = 1; c <= 20; c++) begin
      if (mem_read) begin
        rd_n++;
        if (rd_first == 0) rd_first = c;
      end
      if (mem_write) begin
        wr_n++;
        if (wr_first == 0) wr_first = c;
        wr_addr = mem_address;
        wr_data = mem_write_data;
      end
      if (cpu_ready) begin
        lat = c;
        rdat = cpu_rdata;
        rdy_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic load_chk(input string tag,
                          input logic [31:0] addr,
                          input logic miss,
                          input logic [63:0] exp);
    access(1'b0, addr, 64'h0);
    check({tag, "_lat"}, 64'(lat), miss ? 64'd4 : 64'd1);
    check({tag, "_data"}, rdat, exp);
    check({tag, "_rdcyc"}, 64'(rd_n), miss ? 64'd3 : 64'd0);
    check({tag, "_rdfirst"}, 64'(rd_first), miss ? 64'd1 : 64'd0);
    check({tag, "_nowr"}, 64'(wr_n), 64'd0);
  endtask

  task automatic store_chk(input string tag,
                           input logic [31:0] addr,
                           input logic [63:0] wd,
                           input logic [63:0] old_rd);
    access(1'b1, addr, wd);
    check({tag, "_lat"}, 64'(lat), 64'd2);
    check({tag, "_wrcyc"}, 64'(wr_n), 64'd1);
    check({tag, "_wrfirst"}, 64'(wr_first), 64'd1);
    check({tag, "_addr"}, 64'(wr_addr), 64'(addr));
    check({tag, "_wdata"}, wr_data, wd);
    check({tag, "_nord"}, 64'(rd_n), 64'd0);
    check({tag, "_rdhold"}, rdat, old_rd);
  endtask

  int first_rdy;
  int rc0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(cpu_ready), 64'd0);
    check("rst_mread", 64'(mem_read), 64'd0);
    check("rst_mwrite", 64'(mem_write), 64'd0);
    check("rst_maddr", 64'(mem_address), 64'd0);
    check("rst_mwdata", mem_write_data, 64'd0);
    check("rst_rdata", cpu_rdata, 64'd0);
    rst_n = 1'b1;

    load_chk("miss040", 32'h040, 1'b1, 64'h0706050403020100);
    load_chk("hit048", 32'h048, 1'b0, 64'h0F0E0D0C0B0A0908);
    store_chk("st048", 32'h048, 64'hDEADBEEF_CAFEF00D,
              64'h0F0E0D0C0B0A0908);
    load_chk("hit048b", 32'h048, 1'b0, 64'hDEADBEEF_CAFEF00D);

    store_chk("st200", 32'h200, 64'h11223344_55667788,
              64'hDEADBEEF_CAFEF00D);
    load_chk("ld200", 32'h200, 1'b1, 64'h11223344_55667788);

    load_chk("b2b080", 32'h080, 1'b1, 64'h8786858483828180);
    first_rdy = rdy_cyc;
    load_chk("b2b0c8", 32'h0C8, 1'b1, 64'hCFCECDCCCBCAC9C8);
    check("b2b_gap", 64'(rdy_cyc - first_rdy), 64'd5);

    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h1C0;
    @(negedge clk);
    cpu_req  = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    rc0 = ready_cnt;
    #1;
    check("abort_mread", 64'(mem_read), 64'd0);
    check("abort_rdata", cpu_rdata, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_noready", 64'(ready_cnt - rc0), 64'd0);

    load_chk("re1c0", 32'h1C0, 1'b1, 64'hD7D6D5D4D3D2D1D0);
    load_chk("re080", 32'h080, 1'b1, 64'h8786858483828180);

    load_chk("cf040a", 32'h040, 1'b1, 64'h0706050403020100);
    load_chk("cf140", 32'h140, 1'b1, 64'h5756555453525150);
    load_chk("cf040b", 32'h040, 1'b1, 64'h0706050403020100);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
